// File: rtl/mem_op_sequencer.sv
// Two-operand fetch / ALU execute / write-back sequencer for a 1-cycle-latency register memory.
// Define MEMSEQ_VERIFY_EN to add a read-back verify of the written word (drives err).
module mem_op_sequencer #(
  parameter int unsigned DATA_W = 15,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned OP_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [OP_W-1:0]   opcode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ren,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              wen,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] dataOut,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result
);

  typedef enum logic [3:0] {
    StIdle,
    StIssueA,
    StIssueB,
    StCaptB,
    StExec,
    StWrite,
`ifdef MEMSEQ_VERIFY_EN
    StVfyRd,
    StVfyCmp,
`endif
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   src_b_q, src_b_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [DATA_W-1:0]   result_q, result_d;
`ifdef MEMSEQ_VERIFY_EN
  logic                err_q, err_d;
`endif

  // Outputs are computed alongside the next state so every port is a plain register.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    ren_d     = 1'b0;
    wen_d     = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    src_b_d   = src_b_q;
    dst_d     = dst_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    result_d  = result_q;
`ifdef MEMSEQ_VERIFY_EN
    err_d     = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_b_d   = src_b;
          dst_d     = dst;
          alu_op_d  = opcode;
          ren_d     = 1'b1;
          rd_addr_d = src_a;
`ifdef MEMSEQ_VERIFY_EN
          err_d     = 1'b0;
`endif
          state_d   = StIssueA;
        end
      end
      StIssueA: begin
        ren_d     = 1'b1;
        rd_addr_d = src_b_q;
        state_d   = StIssueB;
      end
      StIssueB: begin
        alu_a_d = dataOut;
        state_d = StCaptB;
      end
      StCaptB: begin
        alu_b_d = dataOut;
        state_d = StExec;
      end
      StExec: begin
        result_d  = alu_result;
        wen_d     = 1'b1;
        wr_addr_d = dst_q;
        state_d   = StWrite;
      end
      StWrite: begin
`ifdef MEMSEQ_VERIFY_EN
        ren_d     = 1'b1;
        rd_addr_d = dst_q;
        state_d   = StVfyRd;
`else
        done_d    = 1'b1;
        state_d   = StDone;
`endif
      end
`ifdef MEMSEQ_VERIFY_EN
      StVfyRd: begin
        state_d = StVfyCmp;
      end
      StVfyCmp: begin
        if (dataOut != result_q) begin
          err_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = StDone;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      result_q  <= '0;
`ifdef MEMSEQ_VERIFY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      result_q  <= result_d;
`ifdef MEMSEQ_VERIFY_EN
      err_q     <= err_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ren    = ren_q;
  assign rdAddr = rd_addr_q;
  assign wen    = wen_q;
  assign wrAddr = wr_addr_q;
  assign dataIn = result_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
`ifdef MEMSEQ_VERIFY_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Directed + randomized bench for mem_op_sequencer with a behavioural memory, ALU and
// reference memory image; honours MEMSEQ_VERIFY_EN when the DUT is built with it.
module tb_mem_op_sequencer;

  localparam int DW = 15;
  localparam int AW = 3;
  localparam int OW = 3;
`ifdef MEMSEQ_VERIFY_EN
  localparam int LAT   = 8;
  localparam int NREAD = 3;
`else
  localparam int LAT   = 6;
  localparam int NREAD = 2;
`endif
  localparam logic [OW-1:0] OpAdd   = 3'd0;
  localparam logic [OW-1:0] OpPassA = 3'd5;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_a, src_b, dst;
  logic [OW-1:0] opcode;
  logic          busy, done, err, ren, wen;
  logic [AW-1:0] rdAddr, wrAddr;
  logic [DW-1:0] dataIn, dataOut, alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_op;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] ref_mem [8];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  logic          corrupt_en;
  int            overlap;
  int            total;
  int            bad;

  always #5 clock = ~clock;

  mem_op_sequencer #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) dut (
    .clock(clock), .reset(reset), .start(start), .src_a(src_a), .src_b(src_b), .dst(dst),
    .opcode(opcode), .busy(busy), .done(done), .err(err), .ren(ren), .rdAddr(rdAddr),
    .wen(wen), .wrAddr(wrAddr), .dataIn(dataIn), .dataOut(dataOut), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
    case (op)
      3'd0:    return DW'(a + b);
      3'd1:    return DW'(a - b);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a;
      3'd6:    return b;
      default: return ~a;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  // Memory: synchronous write, registered read; optional corruption of writes to word 6.
  always_ff @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (wen) mem[wrAddr] <= (corrupt_en && wrAddr == 3'd6) ? (dataIn ^ 15'h0001) : dataIn;
    if (ren) dataOut <= mem[rdAddr];
    if (ren && wen) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic run_cmd(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                         input logic [OW-1:0] op, input logic exp_err);
    logic [DW-1:0] exp_a, exp_b, exp_r, exp_m, wr_d;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wr_a;
    int            cyc, nwr;
    exp_a = ref_mem[a];
    exp_b = ref_mem[b];
    exp_r = alu_f(exp_a, exp_b, op);
    exp_m = exp_err ? (exp_r ^ 15'h0001) : exp_r;
    wr_a = '0; wr_d = '0; nwr = 0;
    check("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; src_a = a; src_b = b; dst = d; opcode = op;
    tick();
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_err_clr", 32'(err), 32'd0);
    cyc = 1;
    while (1) begin
      if (ren) rd_q.push_back(rdAddr);
      if (wen) begin nwr++; wr_a = wrAddr; wr_d = dataIn; end
      if (done || cyc >= 20) break;
      start = 1'($urandom_range(0, 1));
      src_a = AW'($urandom); src_b = AW'($urandom); dst = AW'($urandom);
      opcode = OW'($urandom);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(LAT));
    check("done_busy", 32'(busy), 32'd1);
    check("read_count", 32'(rd_q.size()), 32'(NREAD));
    if (rd_q.size() >= 2) begin
      check("read_addr_a", 32'(rd_q[0]), 32'(a));
      check("read_addr_b", 32'(rd_q[1]), 32'(b));
    end
    if (rd_q.size() >= 3) check("read_addr_vfy", 32'(rd_q[2]), 32'(d));
    check("alu_a", 32'(alu_a), 32'(exp_a));
    check("alu_b", 32'(alu_b), 32'(exp_b));
    check("alu_op", 32'(alu_op), 32'(op));
    check("write_count", 32'(nwr), 32'd1);
    check("write_addr", 32'(wr_a), 32'(d));
    check("write_data", 32'(wr_d), 32'(exp_r));
    check("err_at_done", 32'(err), 32'(exp_err));
    tick();
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("mem_dst", 32'(mem[d]), 32'(exp_m));
    ref_mem[d] = exp_m;
  endtask

  initial begin
    int            done_seen[$];
    int            exp_done[$];
    int            pulses;
    logic [AW-1:0] ra, rb, rd;
    logic [OW-1:0] rop;
    total = 0; bad = 0; overlap = 0; corrupt_en = 1'b0;
    reset = 1'b1; start = 1'b0; src_a = '0; src_b = '0; dst = '0; opcode = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // Preload mem[i] = i while held in reset, then check the reset state.
    tick();
    for (int i = 0; i < 8; i++) bd_write(AW'(i), DW'(i));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ren", 32'(ren), 32'd0);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_rdaddr", 32'(rdAddr), 32'd0);
    check("rst_wraddr", 32'(wrAddr), 32'd0);
    check("rst_datain", 32'(dataIn), 32'd0);
    check("rst_alu", {alu_a, alu_b, 2'b00}, 32'd0);
    check("rst_aluop", 32'(alu_op), 32'd0);
    reset = 1'b0;
    tick();

    // Directed: ADD 2+5 -> 7; then same-address PASS_A of 0x7FFF.
    run_cmd(3'd2, 3'd5, 3'd7, OpAdd, 1'b0);
    bd_write(3'd3, 15'h7FFF);
    run_cmd(3'd3, 3'd3, 3'd3, OpPassA, 1'b0);

    // start held high for 20 cycles: commands accepted every LAT+1 cycles.
    for (int t = 0; t < 20; t += LAT + 1) exp_done.push_back(t + LAT);
    src_a = 3'd1; src_b = 3'd2; dst = 3'd0; opcode = OpAdd;
    for (int c = 0; c < 30; c++) begin
      start = (c < 20);
      if (done) done_seen.push_back(c);
      tick();
    end
    start = 1'b0;
    check("burst_done_count", 32'(done_seen.size()), 32'(exp_done.size()));
    for (int i = 0; i < exp_done.size() && i < done_seen.size(); i++)
      check("burst_done_cycle", 32'(done_seen[i]), 32'(exp_done[i]));
    ref_mem[0] = alu_f(ref_mem[1], ref_mem[2], OpAdd);
    check("burst_mem", 32'(mem[0]), 32'(ref_mem[0]));

    // Reset in the EXEC cycle aborts the command.
    start = 1'b1; src_a = 3'd1; src_b = 3'd2; dst = 3'd5; opcode = OpAdd;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("exec_alu_a", 32'(alu_a), 32'(ref_mem[1]));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wen", 32'(wen), 32'd0);
    check("abort_ren", 32'(ren), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || wen || busy) pulses++;
      tick();
    end
    check("abort_quiet", 32'(pulses), 32'd0);
    check("abort_mem", 32'(mem[5]), 32'(ref_mem[5]));

`ifdef MEMSEQ_VERIFY_EN
    corrupt_en = 1'b1;
    run_cmd(3'd1, 3'd2, 3'd6, OpAdd, 1'b1);
    check("err_hold", 32'(err), 32'd1);
    run_cmd(3'd1, 3'd2, 3'd4, OpAdd, 1'b0);
    corrupt_en = 1'b0;
`endif

    // Randomized commands against the reference memory image.
    for (int n = 0; n < 30; n++) begin
      ra = AW'($urandom); rb = AW'($urandom); rd = AW'($urandom); rop = OW'($urandom);
      if (n % 5 == 0) bd_write(AW'($urandom), DW'($urandom));
      run_cmd(ra, rb, rd, rop, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    check("ren_wen_exclusive", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
